// File: rtl/ysyx_22041211_exec_ctrl_pkg.sv
// Shared definitions for the ysyx_22041211 execution controller.
// Holds the sequencer state encoding, the reset PC and the decoder
// store/load/branch type codes that the controller inspects.
package ysyx_22041211_exec_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    CTRL_IDLE       = 3'd0,
    CTRL_FETCH_REQ  = 3'd1,
    CTRL_FETCH_WAIT = 3'd2,
    CTRL_EXEC       = 3'd3,
    CTRL_MEM_REQ    = 3'd4,
    CTRL_MEM_WAIT   = 3'd5,
    CTRL_WB         = 3'd6
  } ctrl_state_e;

  localparam logic [1:0] STORE_INVALID = 2'd0;
  localparam logic [1:0] STORE_SB      = 2'd1;
  localparam logic [1:0] STORE_SH      = 2'd2;
  localparam logic [1:0] STORE_SW      = 2'd3;

  localparam logic [2:0] LOAD_INVALID  = 3'd0;
  localparam logic [2:0] LOAD_LB       = 3'd1;
  localparam logic [2:0] LOAD_LH       = 3'd2;
  localparam logic [2:0] LOAD_LW       = 3'd3;

  localparam logic [2:0] BRANCH_INVALID = 3'd0;
  localparam logic [2:0] BRANCH_BEQ     = 3'd1;
  localparam logic [2:0] BRANCH_BNE     = 3'd2;

  // True when the decoded instruction needs a data-memory phase.
  function automatic logic is_mem_op(input logic [1:0] store_type,
                                     input logic [2:0] load_type);
    return (store_type != STORE_INVALID) || (load_type != LOAD_INVALID);
  endfunction

endpackage

// File: rtl/ysyx_22041211_exec_ctrl_if.sv
// Bundle of every non-clock/reset signal of the execution controller.
// master: the controller (drives fetch/data requests, PC, IR, strobes).
// slave : the memories plus decoder/ALU datapath surrounding it.
//   ifu_*  : instruction fetch valid/ready request and response
//   lsu_*  : data-memory valid/ready request (with store flag) and response
//   dec_*  : decoder outputs for the held instruction, alu_zero_i from ALU
//   pc_o, inst_o, reg_wen_o, retire_o, state_o : controller status
interface ysyx_22041211_exec_ctrl_if;
  logic        ifu_req_valid_o;
  logic        ifu_req_ready_i;
  logic        ifu_rsp_valid_i;
  logic [31:0] ifu_rsp_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        dec_wd_i;
  logic [1:0]  dec_store_type_i;
  logic [2:0]  dec_load_type_i;
  logic        dec_jmp_flag_i;
  logic [31:0] dec_jmp_target_i;
  logic [2:0]  dec_branch_type_i;
  logic [31:0] dec_branch_target_i;
  logic        alu_zero_i;
  logic        lsu_req_valid_o;
  logic        lsu_req_ready_i;
  logic        lsu_wen_o;
  logic        lsu_rsp_valid_i;
  logic        reg_wen_o;
  logic        retire_o;
  logic [2:0]  state_o;

  modport master (
    output ifu_req_valid_o, pc_o, inst_o, lsu_req_valid_o, lsu_wen_o,
           reg_wen_o, retire_o, state_o,
    input  ifu_req_ready_i, ifu_rsp_valid_i, ifu_rsp_data_i, dec_wd_i,
           dec_store_type_i, dec_load_type_i, dec_jmp_flag_i, dec_jmp_target_i,
           dec_branch_type_i, dec_branch_target_i, alu_zero_i,
           lsu_req_ready_i, lsu_rsp_valid_i
  );

  modport slave (
    input  ifu_req_valid_o, pc_o, inst_o, lsu_req_valid_o, lsu_wen_o,
           reg_wen_o, retire_o, state_o,
    output ifu_req_ready_i, ifu_rsp_valid_i, ifu_rsp_data_i, dec_wd_i,
           dec_store_type_i, dec_load_type_i, dec_jmp_flag_i, dec_jmp_target_i,
           dec_branch_type_i, dec_branch_target_i, alu_zero_i,
           lsu_req_ready_i, lsu_rsp_valid_i
  );
endinterface

// File: rtl/ysyx_22041211_next_pc.sv
// Combinational next-PC select: jump > taken BEQ > sequential.
//   pc_i            : current PC
//   jmp_flag_i/jmp_target_i       : jal/jalr redirect (bit 0 cleared)
//   branch_type_i/branch_target_i : decoded branch and its target
//   alu_zero_i      : ALU compare result, BEQ taken when set
//   next_pc_o       : PC to commit at writeback
module ysyx_22041211_next_pc
  import ysyx_22041211_exec_ctrl_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        jmp_flag_i,
  input  logic [31:0] jmp_target_i,
  input  logic [2:0]  branch_type_i,
  input  logic [31:0] branch_target_i,
  input  logic        alu_zero_i,
  output logic [31:0] next_pc_o
);

  // Priority mux; the +4 wraps naturally at 32 bits.
  always_comb begin
    next_pc_o = pc_i + 32'd4;
    if (jmp_flag_i) begin
      next_pc_o = jmp_target_i & 32'hFFFF_FFFE;
    end else if ((branch_type_i == BRANCH_BEQ) && alu_zero_i) begin
      next_pc_o = branch_target_i;
    end else begin
      next_pc_o = pc_i + 32'd4;
    end
  end

endmodule

// File: rtl/ysyx_22041211_exec_ctrl.sv
// Multi-cycle sequencer: fetch, execute, optional data-memory phase,
// writeback. Owns the PC and instruction register.
//   clk : core clock, rising edge
//   rst : asynchronous active-high reset (state IDLE, pc RESET_PC, inst 0)
//   bus : master side of ysyx_22041211_exec_ctrl_if
module ysyx_22041211_exec_ctrl
  import ysyx_22041211_exec_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_22041211_exec_ctrl_if.master bus
);

  ctrl_state_e state_r;
  ctrl_state_e next_state_s;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [31:0] next_pc_s;
  logic        store_op_s;
  logic        ifu_req_valid_s;
  logic        lsu_req_valid_s;
  logic        lsu_wen_s;
  logic        reg_wen_s;
  logic        retire_s;

  assign store_op_s = (bus.dec_store_type_i != STORE_INVALID);

  ysyx_22041211_next_pc u_next_pc (
    .pc_i            (pc_r),
    .jmp_flag_i      (bus.dec_jmp_flag_i),
    .jmp_target_i    (bus.dec_jmp_target_i),
    .branch_type_i   (bus.dec_branch_type_i),
    .branch_target_i (bus.dec_branch_target_i),
    .alu_zero_i      (bus.alu_zero_i),
    .next_pc_o       (next_pc_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CTRL_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; responses outside their WAIT state are ignored.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      CTRL_IDLE: next_state_s = CTRL_FETCH_REQ;
      CTRL_FETCH_REQ: begin
        if (bus.ifu_req_ready_i) next_state_s = CTRL_FETCH_WAIT;
        else                     next_state_s = CTRL_FETCH_REQ;
      end
      CTRL_FETCH_WAIT: begin
        if (bus.ifu_rsp_valid_i) next_state_s = CTRL_EXEC;
        else                     next_state_s = CTRL_FETCH_WAIT;
      end
      CTRL_EXEC: begin
        if (is_mem_op(bus.dec_store_type_i, bus.dec_load_type_i)) next_state_s = CTRL_MEM_REQ;
        else                                                      next_state_s = CTRL_WB;
      end
      CTRL_MEM_REQ: begin
        if (bus.lsu_req_ready_i) next_state_s = CTRL_MEM_WAIT;
        else                     next_state_s = CTRL_MEM_REQ;
      end
      CTRL_MEM_WAIT: begin
        if (bus.lsu_rsp_valid_i) next_state_s = CTRL_WB;
        else                     next_state_s = CTRL_MEM_WAIT;
      end
      CTRL_WB: next_state_s = CTRL_FETCH_REQ;
      default: next_state_s = CTRL_IDLE;
    endcase
  end

  // PC commits on WB exit; IR loads only on the fetch response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r   <= RESET_PC;
      inst_r <= 32'h0000_0000;
    end else begin
      if ((state_r == CTRL_FETCH_WAIT) && bus.ifu_rsp_valid_i) begin
        inst_r <= bus.ifu_rsp_data_i;
      end
      if (state_r == CTRL_WB) begin
        pc_r <= next_pc_s;
      end
    end
  end

  // Moore output decode; reg_wen also needs the held decoder's wd.
  always_comb begin
    ifu_req_valid_s = 1'b0;
    lsu_req_valid_s = 1'b0;
    lsu_wen_s       = 1'b0;
    reg_wen_s       = 1'b0;
    retire_s        = 1'b0;
    case (state_r)
      CTRL_FETCH_REQ: ifu_req_valid_s = 1'b1;
      CTRL_MEM_REQ: begin
        lsu_req_valid_s = 1'b1;
        lsu_wen_s       = store_op_s;
      end
      CTRL_MEM_WAIT: lsu_wen_s = store_op_s;
      CTRL_WB: begin
        reg_wen_s = bus.dec_wd_i;
        retire_s  = 1'b1;
      end
      default: begin
        ifu_req_valid_s = 1'b0;
        lsu_req_valid_s = 1'b0;
      end
    endcase
  end

  assign bus.ifu_req_valid_o = ifu_req_valid_s;
  assign bus.lsu_req_valid_o = lsu_req_valid_s;
  assign bus.lsu_wen_o       = lsu_wen_s;
  assign bus.reg_wen_o       = reg_wen_s;
  assign bus.retire_o        = retire_s;
  assign bus.pc_o            = pc_r;
  assign bus.inst_o          = inst_r;
  assign bus.state_o         = state_r;

endmodule

// File: tb/tb_ysyx_22041211_exec_ctrl.sv
// Directed bench for ysyx_22041211_exec_ctrl with a retire scoreboard.
module tb_ysyx_22041211_exec_ctrl;
  import ysyx_22041211_exec_ctrl_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [31:0] npc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22041211_exec_ctrl_if bus ();

  ysyx_22041211_exec_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  int          retire_cnt = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [31:0] model_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.retire_o === 1'b1) retire_cnt++;
  endtask

  task automatic set_dec(input logic wd, input logic [1:0] st, input logic [2:0] ld,
                         input logic jf, input logic [31:0] jt, input logic [2:0] bt,
                         input logic [31:0] btg, input logic zero);
    bus.dec_wd_i            = wd;
    bus.dec_store_type_i    = st;
    bus.dec_load_type_i     = ld;
    bus.dec_jmp_flag_i      = jf;
    bus.dec_jmp_target_i    = jt;
    bus.dec_branch_type_i   = bt;
    bus.dec_branch_target_i = btg;
    bus.alu_zero_i          = zero;
  endtask

  // Plays memory and decoder for one instruction, starting in FETCH_REQ.
  task automatic run_instr(input string name, input logic [31:0] inst, input logic wd,
                           input logic [1:0] st, input logic [2:0] ld, input logic jf,
                           input logic [31:0] jt, input logic [2:0] bt, input logic [31:0] btg,
                           input logic zero, input int ifu_dly, input int lsu_dly,
                           input int rsp_dly, input logic stray);
    exp_t e;
    logic mem;
    int   start;
    mem   = (st != STORE_INVALID) || (ld != LOAD_INVALID);
    e.pc  = model_pc;
    e.inst = inst;
    e.wen = wd;
    if (jf)                             e.npc = jt & 32'hFFFF_FFFE;
    else if (bt == BRANCH_BEQ && zero)  e.npc = btg;
    else                                e.npc = model_pc + 32'd4;
    sb.push_back(e);
    set_dec(wd, st, ld, jf, jt, bt, btg, zero);
    retire_cnt = 0;
    start = cyc;

    chk({name, ".req_state"}, 32'(bus.state_o), 32'(CTRL_FETCH_REQ));
    chk1({name, ".req_valid"}, bus.ifu_req_valid_o, 1'b1);
    chk({name, ".req_pc"}, bus.pc_o, model_pc);
    for (int i = 0; i < ifu_dly; i++) begin
      bus.ifu_req_ready_i = 1'b0;
      tick();
      chk1({name, ".bp_valid"}, bus.ifu_req_valid_o, 1'b1);
      chk({name, ".bp_pc"}, bus.pc_o, model_pc);
      chk({name, ".bp_state"}, 32'(bus.state_o), 32'(CTRL_FETCH_REQ));
    end
    bus.ifu_req_ready_i = 1'b1;
    tick();
    bus.ifu_req_ready_i = 1'b0;
    chk({name, ".fw_state"}, 32'(bus.state_o), 32'(CTRL_FETCH_WAIT));
    bus.ifu_rsp_valid_i = 1'b1;
    bus.ifu_rsp_data_i  = inst;
    tick();
    bus.ifu_rsp_valid_i = 1'b0;
    chk({name, ".exec_state"}, 32'(bus.state_o), 32'(CTRL_EXEC));
    chk({name, ".inst"}, bus.inst_o, inst);
    if (stray) begin
      bus.ifu_rsp_valid_i = 1'b1;
      bus.ifu_rsp_data_i  = ~inst;
    end
    tick();
    bus.ifu_rsp_valid_i = 1'b0;
    chk({name, ".inst_hold"}, bus.inst_o, inst);

    if (mem) begin
      chk({name, ".mreq_state"}, 32'(bus.state_o), 32'(CTRL_MEM_REQ));
      chk1({name, ".mreq_valid"}, bus.lsu_req_valid_o, 1'b1);
      chk1({name, ".mreq_wen"}, bus.lsu_wen_o, st != STORE_INVALID);
      for (int i = 0; i < lsu_dly; i++) begin
        bus.lsu_req_ready_i = 1'b0;
        tick();
        chk1({name, ".mbp_valid"}, bus.lsu_req_valid_o, 1'b1);
        chk1({name, ".mbp_wen"}, bus.lsu_wen_o, st != STORE_INVALID);
      end
      bus.lsu_req_ready_i = 1'b1;
      tick();
      bus.lsu_req_ready_i = 1'b0;
      chk({name, ".mwait_state"}, 32'(bus.state_o), 32'(CTRL_MEM_WAIT));
      chk1({name, ".mwait_wen"}, bus.lsu_wen_o, st != STORE_INVALID);
      chk1({name, ".mwait_valid"}, bus.lsu_req_valid_o, 1'b0);
      for (int i = 0; i < rsp_dly; i++) tick();
      bus.lsu_rsp_valid_i = 1'b1;
      tick();
      bus.lsu_rsp_valid_i = 1'b0;
    end

    chk({name, ".wb_state"}, 32'(bus.state_o), 32'(CTRL_WB));
    chk1({name, ".wb_retire"}, bus.retire_o, 1'b1);
    chk1({name, ".sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk1({name, ".wb_reg_wen"}, bus.reg_wen_o, e.wen);
      chk({name, ".wb_pc"}, bus.pc_o, e.pc);
      chk({name, ".wb_inst"}, bus.inst_o, e.inst);
    end
    tick();
    chk({name, ".next_state"}, 32'(bus.state_o), 32'(CTRL_FETCH_REQ));
    chk({name, ".next_pc"}, bus.pc_o, e.npc);
    chk1({name, ".post_reg_wen"}, bus.reg_wen_o, 1'b0);
    chk({name, ".retire_cnt"}, 32'(retire_cnt), 32'd1);
    chk({name, ".cycles"}, 32'(cyc - start),
        32'(4 + (mem ? 2 : 0) + ifu_dly + lsu_dly + rsp_dly));
    model_pc = e.npc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.ifu_req_ready_i = 1'b0;
    bus.ifu_rsp_valid_i = 1'b0;
    bus.ifu_rsp_data_i  = 32'h0;
    bus.lsu_req_ready_i = 1'b0;
    bus.lsu_rsp_valid_i = 1'b0;
    set_dec(1'b0, STORE_INVALID, LOAD_INVALID, 1'b0, 32'h0, BRANCH_INVALID, 32'h0, 1'b0);
    model_pc = RESET_PC_DEFAULT;
    tick();
    tick();
    chk("rst.state", 32'(bus.state_o), 32'(CTRL_IDLE));
    chk("rst.pc", bus.pc_o, RESET_PC_DEFAULT);
    chk("rst.inst", bus.inst_o, 32'h0);
    chk1("rst.ifu_valid", bus.ifu_req_valid_o, 1'b0);
    chk1("rst.lsu_valid", bus.lsu_req_valid_o, 1'b0);
    chk1("rst.lsu_wen", bus.lsu_wen_o, 1'b0);
    chk1("rst.reg_wen", bus.reg_wen_o, 1'b0);
    chk1("rst.retire", bus.retire_o, 1'b0);
    rst = 1'b0;
    tick();

    //          name         inst          wd    store          load          jf    jt              bt              btg            z     ifu lsu rsp stray
    run_instr("addi",      32'h00100093, 1'b1, STORE_INVALID, LOAD_INVALID, 1'b0, 32'h0,         BRANCH_INVALID, 32'h0,         1'b0, 0, 0, 0, 1'b0);
    run_instr("addi_bp",   32'h00200113, 1'b1, STORE_INVALID, LOAD_INVALID, 1'b0, 32'h0,         BRANCH_INVALID, 32'h0,         1'b0, 3, 0, 0, 1'b0);
    run_instr("sw",        32'h00112023, 1'b0, STORE_SW,      LOAD_INVALID, 1'b0, 32'h0,         BRANCH_INVALID, 32'h0,         1'b0, 0, 2, 0, 1'b0);
    run_instr("lw",        32'h00012183, 1'b1, STORE_INVALID, LOAD_LW,      1'b0, 32'h0,         BRANCH_INVALID, 32'h0,         1'b0, 0, 0, 0, 1'b0);
    run_instr("beq_t",     32'h02208863, 1'b0, STORE_INVALID, LOAD_INVALID, 1'b0, 32'h0,         BRANCH_BEQ,     32'h8000_0040, 1'b1, 0, 0, 0, 1'b0);
    run_instr("beq_nt",    32'h02208863, 1'b0, STORE_INVALID, LOAD_INVALID, 1'b0, 32'h0,         BRANCH_BEQ,     32'h8000_0080, 1'b0, 0, 0, 0, 1'b0);
    run_instr("jalr",      32'h000080e7, 1'b1, STORE_INVALID, LOAD_INVALID, 1'b1, 32'h8000_0103, BRANCH_INVALID, 32'h0,         1'b0, 0, 0, 0, 1'b1);
    run_instr("jal_beq",   32'h0000006f, 1'b0, STORE_INVALID, LOAD_INVALID, 1'b1, 32'hFFFF_FFFC, BRANCH_BEQ,     32'h8000_0080, 1'b1, 0, 0, 0, 1'b0);
    run_instr("wrap",      32'h00100093, 1'b1, STORE_INVALID, LOAD_INVALID, 1'b0, 32'h0,         BRANCH_INVALID, 32'h0,         1'b0, 0, 0, 0, 1'b0);
    chk("wrap.pc_zero", model_pc, 32'h0000_0000);

    // Reset while a load waits in MEM_WAIT; late responses must be dropped.
    set_dec(1'b1, STORE_INVALID, LOAD_LW, 1'b0, 32'h0, BRANCH_INVALID, 32'h0, 1'b0);
    bus.ifu_req_ready_i = 1'b1;
    tick();
    bus.ifu_req_ready_i = 1'b0;
    bus.ifu_rsp_valid_i = 1'b1;
    bus.ifu_rsp_data_i  = 32'h00012183;
    tick();
    bus.ifu_rsp_valid_i = 1'b0;
    tick();
    bus.lsu_req_ready_i = 1'b1;
    tick();
    bus.lsu_req_ready_i = 1'b0;
    chk("mrst.pre_state", 32'(bus.state_o), 32'(CTRL_MEM_WAIT));
    retire_cnt = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst.state", 32'(bus.state_o), 32'(CTRL_IDLE));
    chk("mrst.pc", bus.pc_o, RESET_PC_DEFAULT);
    chk1("mrst.lsu_valid", bus.lsu_req_valid_o, 1'b0);
    bus.lsu_rsp_valid_i = 1'b1;
    tick();
    chk("mrst.hold_state", 32'(bus.state_o), 32'(CTRL_IDLE));
    chk1("mrst.reg_wen", bus.reg_wen_o, 1'b0);
    rst = 1'b0;
    #1;
    chk("mrst.idle_state", 32'(bus.state_o), 32'(CTRL_IDLE));
    tick();
    bus.lsu_rsp_valid_i = 1'b0;
    chk("mrst.restart_state", 32'(bus.state_o), 32'(CTRL_FETCH_REQ));
    chk("mrst.restart_pc", bus.pc_o, RESET_PC_DEFAULT);
    chk1("mrst.restart_valid", bus.ifu_req_valid_o, 1'b1);
    chk1("mrst.reg_wen_after", bus.reg_wen_o, 1'b0);
    chk("mrst.no_retire", 32'(retire_cnt), 32'd0);
    sb.delete();
    model_pc = RESET_PC_DEFAULT;
    run_instr("post_rst",  32'h00300193, 1'b1, STORE_INVALID, LOAD_INVALID, 1'b0, 32'h0,         BRANCH_INVALID, 32'h0,         1'b0, 0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
